// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and master identifiers for the arbiter slice.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } master_e;

  // NONSEQ and SEQ both have HTRANS[1] set; IDLE and BUSY do not.
  function automatic logic htrans_req(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_grant_fsm.sv
// Address-phase / data-phase ownership tracker for the two-master arbiter.
module ahb_grant_fsm
  import ahb_lite_pkg::*;
#(
  parameter int unsigned PARK_M = 0
) (
  input  logic    HCLK,
  input  logic    HRESETn,
  input  logic    req0,
  input  logic    req1,
  input  logic    owner_idle,
  input  logic    HREADY,
  output master_e addr_own,
  output master_e data_own,
  output logic    data_act
);

  localparam master_e PARK = (PARK_M == 0) ? MST_M0 : MST_M1;

  master_e addr_own_q, addr_own_d;
  master_e data_own_q, data_own_d;
  logic    data_act_q, data_act_d;
  logic    owner_req;
  logic    other_req;

  // Ownership registers; reset abandons any outstanding transfer.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_own_q <= PARK;
      data_own_q <= PARK;
      data_act_q <= 1'b0;
    end else begin
      addr_own_q <= addr_own_d;
      data_own_q <= data_own_d;
      data_act_q <= data_act_d;
    end
  end

  // Advance the data phase on HREADY; hand the address phase over only when
  // the owner is IDLE, so bursts and BUSY beats are never split.
  always_comb begin
    addr_own_d = addr_own_q;
    data_own_d = data_own_q;
    data_act_d = data_act_q;
    owner_req  = (addr_own_q == MST_M1) ? req1 : req0;
    other_req  = (addr_own_q == MST_M1) ? req0 : req1;
    if (HREADY) begin
      data_own_d = addr_own_q;
      data_act_d = owner_req;
      if (owner_idle && other_req) begin
        addr_own_d = (addr_own_q == MST_M0) ? MST_M1 : MST_M0;
      end
    end
  end

  assign addr_own = addr_own_q;
  assign data_own = data_own_q;
  assign data_act = data_act_q;

endmodule

// File: rtl/ahb_lite_master_arbiter.sv
// Two-master AHB-Lite arbiter: M0 = CPU, M1 = accelerator/DMA.
module ahb_lite_master_arbiter
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PARK_M = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic              M0_HREADY,
  output logic              M0_HRESP,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic              M1_HREADY,
  output logic              M1_HRESP,
  output logic [DATA_W-1:0] HRDATA_M,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              GNT
);

  master_e addr_own;
  master_e data_own;
  logic    data_act;
  logic    req0;
  logic    req1;
  logic    owner_idle;

  assign req0 = htrans_req(M0_HTRANS);
  assign req1 = htrans_req(M1_HTRANS);

  ahb_grant_fsm #(
    .PARK_M (PARK_M)
  ) u_grant (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .req0       (req0),
    .req1       (req1),
    .owner_idle (owner_idle),
    .HREADY     (HREADY),
    .addr_own   (addr_own),
    .data_own   (data_own),
    .data_act   (data_act)
  );

  // Address/control mux follows the address-phase owner.
  always_comb begin
    HADDR  = M0_HADDR;
    HTRANS = M0_HTRANS;
    HWRITE = M0_HWRITE;
    HSIZE  = M0_HSIZE;
    if (addr_own == MST_M1) begin
      HADDR  = M1_HADDR;
      HTRANS = M1_HTRANS;
      HWRITE = M1_HWRITE;
      HSIZE  = M1_HSIZE;
    end
    owner_idle = (HTRANS == HTRANS_IDLE);
  end

  // Write data follows the data-phase owner, one beat behind the address.
  always_comb begin
    HWDATA = (data_own == MST_M1) ? M1_HWDATA : M0_HWDATA;
  end

  // Owner sees the slave's HREADY; a requesting non-owner is stalled.
  always_comb begin
    M0_HREADY = 1'b1;
    M1_HREADY = 1'b1;
    if (addr_own == MST_M0) M0_HREADY = HREADY;
    else if (req0)          M0_HREADY = 1'b0;
    if (addr_own == MST_M1) M1_HREADY = HREADY;
    else if (req1)          M1_HREADY = 1'b0;
  end

  // Responses reach only the master with a live data phase.
  always_comb begin
    M0_HRESP = HRESP_OKAY;
    M1_HRESP = HRESP_OKAY;
    if (data_act && data_own == MST_M0) M0_HRESP = HRESP;
    if (data_act && data_own == MST_M1) M1_HRESP = HRESP;
  end

  assign HRDATA_M = HRDATA;
  assign GNT      = (addr_own == MST_M1);

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Directed, table-driven bench for the two-master AHB-Lite arbiter.
module tb_ahb_lite_master_arbiter;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] S = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        M0_HREADY, M1_HREADY;
  logic        M0_HRESP, M1_HRESP;
  logic [31:0] HRDATA_M, HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP, GNT;
  logic [2:0]  HSIZE;

  int unsigned total  = 0;
  int unsigned passed = 0;

  ahb_lite_master_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .PARK_M (0)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .M0_HADDR  (M0_HADDR),
    .M0_HTRANS (M0_HTRANS),
    .M0_HWRITE (M0_HWRITE),
    .M0_HSIZE  (M0_HSIZE),
    .M0_HWDATA (M0_HWDATA),
    .M0_HREADY (M0_HREADY),
    .M0_HRESP  (M0_HRESP),
    .M1_HADDR  (M1_HADDR),
    .M1_HTRANS (M1_HTRANS),
    .M1_HWRITE (M1_HWRITE),
    .M1_HSIZE  (M1_HSIZE),
    .M1_HWDATA (M1_HWDATA),
    .M1_HREADY (M1_HREADY),
    .M1_HRESP  (M1_HRESP),
    .HRDATA_M  (HRDATA_M),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .GNT       (GNT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0]  m0t;
    logic [31:0] m0a;
    logic [1:0]  m1t;
    logic [31:0] m1a;
    logic        hr;
    logic        resp;
    logic        gnt;
    logic [1:0]  htr;
    logic [31:0] haddr;
    logic        m0r;
    logic        m1r;
    logic        m0e;
    logic        m1e;
    logic        wsrc;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic [1:0] m0t, input logic [31:0] m0a,
                              input logic [1:0] m1t, input logic [31:0] m1a,
                              input logic hr, input logic resp,
                              input logic gnt, input logic [1:0] htr,
                              input logic [31:0] haddr,
                              input logic m0r, input logic m1r,
                              input logic m0e, input logic m1e,
                              input logic wsrc);
    vec_t v;
    v.m0t = m0t; v.m0a = m0a; v.m1t = m1t; v.m1a = m1a;
    v.hr = hr; v.resp = resp; v.gnt = gnt; v.htr = htr; v.haddr = haddr;
    v.m0r = m0r; v.m1r = m1r; v.m0e = m0e; v.m1e = m1e; v.wsrc = wsrc;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input logic [1:0] m0t, input logic [31:0] m0a,
                       input logic [1:0] m1t, input logic [31:0] m1a,
                       input logic hr, input logic resp, input int idx);
    M0_HTRANS = m0t; M0_HADDR = m0a;
    M1_HTRANS = m1t; M1_HADDR = m1a;
    HREADY = hr; HRESP = resp;
    M0_HWDATA = 32'hA0A0_0000 + 32'(idx);
    M1_HWDATA = 32'hB1B1_0000 + 32'(idx);
    HRDATA    = 32'hC0DE_0000 + 32'(idx);
  endtask

  initial begin
    //           m0t m0a           m1t m1a           hr resp gnt htr haddr        m0r m1r m0e m1e ws
    vecs[0]  = mk(I, 32'h0,        I, 32'h0,        1, 0,   0,  I, 32'h0,        1,  1,  0,  0,  0);
    vecs[1]  = mk(I, 32'h0,        N, 32'h4000_0000, 1, 0,  0,  I, 32'h0,        1,  0,  0,  0,  0);
    vecs[2]  = mk(I, 32'h0,        N, 32'h4000_0000, 1, 0,  1,  N, 32'h4000_0000, 1, 1,  0,  0,  0);
    vecs[3]  = mk(I, 32'h0,        I, 32'h4000_0000, 1, 0,  1,  I, 32'h4000_0000, 1, 1,  0,  0,  1);
    vecs[4]  = mk(N, 32'h2000_0000, I, 32'h0,       1, 0,   1,  I, 32'h0,        0,  1,  0,  0,  1);
    vecs[5]  = mk(N, 32'h2000_0000, N, 32'h4000_0010, 1, 0, 0,  N, 32'h2000_0000, 1, 0,  0,  0,  1);
    vecs[6]  = mk(S, 32'h2000_0004, N, 32'h4000_0010, 1, 0, 0,  S, 32'h2000_0004, 1, 0,  0,  0,  0);
    vecs[7]  = mk(S, 32'h2000_0008, N, 32'h4000_0010, 1, 0, 0,  S, 32'h2000_0008, 1, 0,  0,  0,  0);
    vecs[8]  = mk(S, 32'h2000_000C, N, 32'h4000_0010, 1, 0, 0,  S, 32'h2000_000C, 1, 0,  0,  0,  0);
    vecs[9]  = mk(I, 32'h2000_000C, N, 32'h4000_0010, 0, 0, 0,  I, 32'h2000_000C, 0, 0,  0,  0,  0);
    vecs[10] = mk(I, 32'h2000_000C, N, 32'h4000_0010, 0, 0, 0,  I, 32'h2000_000C, 0, 0,  0,  0,  0);
    vecs[11] = mk(I, 32'h2000_000C, N, 32'h4000_0010, 1, 0, 0,  I, 32'h2000_000C, 1, 0,  0,  0,  0);
    vecs[12] = mk(I, 32'h0,        N, 32'h4000_0010, 1, 0,  1,  N, 32'h4000_0010, 1, 1,  0,  0,  0);
    vecs[13] = mk(I, 32'h0,        I, 32'h4000_0010, 0, 1,  1,  I, 32'h4000_0010, 1, 0,  0,  1,  1);
    vecs[14] = mk(I, 32'h0,        I, 32'h4000_0010, 1, 1,  1,  I, 32'h4000_0010, 1, 1,  0,  1,  1);
    vecs[15] = mk(I, 32'h0,        I, 32'h0,        1, 0,   1,  I, 32'h0,        1,  1,  0,  0,  1);
    vecs[16] = mk(I, 32'h0,        I, 32'h0,        1, 1,   1,  I, 32'h0,        1,  1,  0,  0,  1);
    vecs[17] = mk(N, 32'h2000_0000, B, 32'h4000_0014, 1, 0, 1,  B, 32'h4000_0014, 0, 1,  0,  0,  1);
    vecs[18] = mk(N, 32'h2000_0000, I, 32'h0,       1, 0,   1,  I, 32'h0,        0,  1,  0,  0,  1);
    vecs[19] = mk(N, 32'h2000_0000, I, 32'h0,       1, 0,   0,  N, 32'h2000_0000, 1, 1,  0,  0,  1);

    M0_HWRITE = 1'b1; M0_HSIZE = 3'b010;
    M1_HWRITE = 1'b0; M1_HSIZE = 3'b001;
    HRESETn = 1'b0;
    drive(I, 32'h0, I, 32'h0, 1'b1, 1'b0, 0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge HCLK);
      drive(vecs[i].m0t, vecs[i].m0a, vecs[i].m1t, vecs[i].m1a,
            vecs[i].hr, vecs[i].resp, i);
      #1;
      check("gnt",    i, 32'(GNT),       32'(vecs[i].gnt));
      check("htrans", i, 32'(HTRANS),    32'(vecs[i].htr));
      check("haddr",  i, HADDR,          vecs[i].haddr);
      check("hwrite", i, 32'(HWRITE),    32'(!vecs[i].gnt));
      check("hsize",  i, 32'(HSIZE),     vecs[i].gnt ? 32'd1 : 32'd2);
      check("hwdata", i, HWDATA,
            vecs[i].wsrc ? 32'hB1B1_0000 + 32'(i) : 32'hA0A0_0000 + 32'(i));
      check("m0_hready", i, 32'(M0_HREADY), 32'(vecs[i].m0r));
      check("m1_hready", i, 32'(M1_HREADY), 32'(vecs[i].m1r));
      check("m0_hresp",  i, 32'(M0_HRESP),  32'(vecs[i].m0e));
      check("m1_hresp",  i, 32'(M1_HRESP),  32'(vecs[i].m1e));
      check("hrdata_m",  i, HRDATA_M,       32'hC0DE_0000 + 32'(i));
    end

    // Reset in the middle of an M1 burst.
    @(negedge HCLK);
    drive(I, 32'h0, N, 32'h4000_0020, 1'b1, 1'b0, 100);
    #1;
    check("rst_pre_gnt",  100, 32'(GNT),       32'd0);
    check("rst_pre_m1r",  100, 32'(M1_HREADY), 32'd0);
    @(negedge HCLK);
    drive(I, 32'h0, S, 32'h4000_0024, 1'b1, 1'b0, 101);
    #1;
    check("rst_burst_gnt", 101, 32'(GNT),    32'd1);
    check("rst_burst_htr", 101, 32'(HTRANS), 32'(S));
    @(negedge HCLK);
    drive(I, 32'h0, S, 32'h4000_0028, 1'b0, 1'b1, 102);
    #1;
    check("rst_live_m1e", 102, 32'(M1_HRESP), 32'd1);
    HRESETn = 1'b0;
    @(negedge HCLK);
    drive(I, 32'h0, S, 32'h4000_0028, 1'b1, 1'b1, 103);
    #1;
    check("rst_gnt",   103, 32'(GNT),       32'd0);
    check("rst_htr",   103, 32'(HTRANS),    32'(I));
    check("rst_m1e",   103, 32'(M1_HRESP),  32'd0);
    check("rst_m0e",   103, 32'(M0_HRESP),  32'd0);
    check("rst_m1r",   103, 32'(M1_HREADY), 32'd0);
    check("rst_haddr", 103, HADDR,          32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    check("post_rst_gnt", 104, 32'(GNT), 32'd0);
    @(negedge HCLK);
    #1;
    check("regrant_gnt",  105, 32'(GNT),    32'd1);
    check("regrant_addr", 105, HADDR,       32'h4000_0028);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach end, got running expected finished");
    $fatal(1);
  end

endmodule
